// File: rtl/tff_updown_counter_pkg.sv
// rtl/tff_updown_counter_pkg.sv - shared constants and width helpers for the toggle-cell counter
package tff_updown_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Prescaler counter width, never narrower than one bit.
   function automatic int pcnt_width(input int prescale);
      return (clog2(prescale) < 1) ? 1 : clog2(prescale);
   endfunction

endpackage

// File: rtl/tff_updown_counter_if.sv
// rtl/tff_updown_counter_if.sv - control/status bundle between a counter and its user
interface tff_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             sat_mode;
   logic             clr_ovf;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, load, load_val, sat_mode, clr_ovf,
      input  q, tc, ovf
   );

   modport slave (
      input  en, up, load, load_val, sat_mode, clr_ovf,
      output q, tc, ovf
   );
endinterface

// File: rtl/tff_updown_counter_tff_cell.sv
// rtl/tff_updown_counter_tff_cell.sv - one counter bit: T flip-flop with parallel load
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   input  logic ld,
   input  logic d,
   input  logic rst_val,
   output logic q
);
   logic q_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= rst_val;
      end else if (ld) begin
         q_q <= d;
      end else if (t) begin
         q_q <= ~q_q;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/tff_updown_counter.sv
// rtl/tff_updown_counter.sv - up/down counter built from a chain of toggle cells
module tff_updown_counter
   import tff_updown_counter_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               PRESCALE  = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   tff_updown_counter_if.slave bus
);
   localparam int            PW   = pcnt_width(PRESCALE);
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] carry, borrow, t_en;
   logic             step, boundary, hold_sat;

   always_comb begin
      pcnt_d = pcnt_q;
      if (bus.load) begin
         pcnt_d = '0;
      end else if (bus.en) begin
         pcnt_d = (pcnt_q == PMAX) ? '0 : pcnt_q + 1'b1;
      end
   end

   // Load outranks a step, so a loading edge never counts as a boundary.
   assign step     = bus.en & (pcnt_q == PMAX) & ~bus.load;
   assign boundary = step & ((bus.up == DIR_UP) ? (&q) : ~(|q));
   assign hold_sat = boundary & (bus.sat_mode == MODE_SAT);

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_chain
         assign carry[gi]  = carry[gi-1] & q[gi-1];
         assign borrow[gi] = borrow[gi-1] & ~q[gi-1];
      end
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign t_en[gi] = step & ~hold_sat & ((bus.up == DIR_UP) ? carry[gi] : borrow[gi]);
         tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .t       (t_en[gi]),
            .ld      (bus.load),
            .d       (bus.load_val[gi]),
            .rst_val (RESET_VAL[gi]),
            .q       (q[gi])
         );
      end
   endgenerate

   assign tc_d  = boundary;
   assign ovf_d = boundary | (ovf_q & ~bus.clr_ovf);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt_q <= '0;
         tc_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         tc_q   <= tc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.q   = q;
   assign bus.tc  = tc_q;
   assign bus.ovf = ovf_q;
endmodule
